spi_cmd_rx: RTL
===============

# spi_cmd_rx

Clock-domain-crossing SPI slave receiver producing the 8-bit display command byte `val` for the LED matrix core. It oversamples the asynchronous `sck`/`sdi`/`load` pins with `clk`, assembles MSB-first frames and validates their length. It commits a byte atomically, so the matrix core never sees a partially shifted command. It replaces the free-running `sck`-clocked shift register in front of the LED multiplexer.

## Interface
- `RESET_VAL`, default 8'h00: value of `val` after reset. Bit 5 = 0 selects scroll mode in the core; bit 0 = 0 selects the moon animation.
- `TIMEOUT`, default 1048575: number of `clk` cycles with `load` high and no `sck` rising edge before the frame is aborted. Must be ≥ 1.
- `clk`, input, 1: system clock (HSOSC, 24 MHz).
- `reset`, input, 1: synchronous, active-low reset.
- `sck`, input, 1: SPI clock, asynchronous. Mode 0: sample on rising edge.
- `sdi`, input, 1: SPI data, MSB first, asynchronous.
- `load`, input, 1: frame enable, active high, asynchronous.
- `val`, output, 8: last committed command byte.
- `val_valid`, output, 1: one-cycle pulse when `val` is updated.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected.
- `busy`, output, 1: high while a frame is being received (state ACTIVE).
- `sdo`, output, 1: readback data. Constant 0 unless `SPI_CMD_RX_READBACK_EN` is defined.

## Operation
- Synchronizers: each of `sck`, `sdi` and `load` passes through 2 flops (s1, s2), followed by a third flop (s3) for edge detection.
  - A rising edge is `s2 & ~s3`; a falling edge is `~s2 & s3`.
- Datapath:
  - 8-bit shift register `shreg`.
  - 4-bit bit counter `cnt`, saturating at 9.
  - Timeout counter, wide enough for `TIMEOUT`.
- FSM states: IDLE, ACTIVE, ABORT.
  - IDLE → ACTIVE on a `load` rising edge. `cnt` ← 0 and the timeout counter ← 0.
  - ACTIVE, on an `sck` rising edge with `load` s2 high:
    - `shreg` ← {`shreg[6:0]`, `sdi` s2}.
    - `cnt` ← min(`cnt`+1, 9).
    - Timeout counter ← 0.
  - ACTIVE, no `sck` edge: timeout counter increments.
  - ACTIVE → IDLE on a `load` falling edge:
    - If `cnt` == 8: `val` ← `shreg` and `val_valid` pulses.
    - Otherwise: `frame_err` pulses and `val` is held.
  - ACTIVE → ABORT when the timeout counter reaches `TIMEOUT`. `frame_err` pulses and `val` is held.
  - ABORT → IDLE on a `load` falling edge. No pulse. All `sck` edges are ignored in ABORT.
- A frame already in progress when reset is released is ignored: IDLE requires a `load` rising edge, not a high level.
- Simultaneous `sck` rising edge and `load` falling edge in the same cycle: the bit is dropped, because `load` s2 is already low. The length check uses `cnt` without that bit.
- `sdi` is sampled from s2 in the same cycle that the `sck` s2/s3 edge is seen. The aligned sync depth guarantees mode-0 setup.
- `sck` edges in IDLE are ignored. `shreg` contents carry no meaning outside ACTIVE.

## Timing
- Reset values:
  - `val` = `RESET_VAL`.
  - `val_valid`, `frame_err`, `busy` and `sdo` = 0.
  - State = IDLE; all counters = 0; `shreg` = 0.
- Pin-to-output latency: a pin change first sampled at `clk` edge k is acted on at edge k+2. `val`, `val_valid`, `frame_err` and `busy` are registered and change at edge k+2.
- `val` changes only in the same cycle that `val_valid` is high. It is stable in every other cycle.
- `val_valid` and `frame_err` are mutually exclusive and are never high for two consecutive cycles.
- Pin constraints:
  - `sck` high and low each ≥ 3 `clk` periods (SCK ≤ 4 MHz at 24 MHz `clk`).
  - `load` low between frames ≥ 3 `clk` periods.
  - `sdi` stable from 1 period before to 3 periods after the `sck` rising edge.
- Timeout fires exactly `TIMEOUT` cycles after the last accepted `sck` edge (or after frame start). `frame_err` is registered one cycle later.

## Configuration
- `SPI_CMD_RX_READBACK_EN` defined: an 8-bit `txreg` is loaded with `val` on the IDLE→ACTIVE transition.
  - `sdo` = `txreg[7]`, valid before the first `sck` rising edge.
  - On each `sck` falling edge in ACTIVE: `txreg` ← {`txreg[6:0]`, 0}.
  - The master reads the previous command while it sends the new one.
- Not defined: no `txreg` is instantiated and `sdo` is tied to 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles while toggling the pins → `val`=8'h00, `val_valid`=`frame_err`=`busy`=0. Changing `RESET_VAL` to 8'h20 gives `val`=8'h20.
- Nominal: send 8'hA5 (8 bits, SCK = `clk`/8) → exactly one `val_valid` pulse, 3 edges after `load` falls; `val`=8'hA5; `busy` high only during the frame.
- Short/long frames after A5: a 7-bit frame and then a 9-bit frame → one `frame_err` pulse each; `val` stays 8'hA5 and `val_valid` never pulses.
- Timeout with `TIMEOUT`=16: raise `load`, send 3 bits, stall → `frame_err` at 17 cycles; extra `sck` edges are ignored. Drop `load`, then send 8'h3C → `val`=8'h3C.
- Reset mid-frame: after 4 bits, pulse `reset` low with `load` still high, finish 4 more bits, drop `load` → no `val_valid` and no `frame_err`; `val`=8'h00.
- Readback (macro defined): with `val`=8'hA5, send 8'h3C → `sdo` sampled on rising edges reads 1,0,1,0,0,1,0,1; `val`=8'h3C. Macro undefined: `sdo`=0 throughout.

Source files
------------

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver: oversamples sck/sdi/load with clk and commits one validated 8-bit byte per frame.
// Optional readback of the previous command on sdo when SPI_CMD_RX_READBACK_EN is defined.
module spi_cmd_rx #(
  parameter logic [7:0]  RESET_VAL = 8'h00,
  parameter int unsigned TIMEOUT   = 1048575
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       load,
  output logic [7:0] val,
  output logic       val_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       sdo
);

  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [3:0]    cnt;
  logic [TW-1:0] tmo;

  logic sck_s1, sck_s2, sck_s3;
  logic load_s1, load_s2, load_s3;
  logic sdi_s1, sdi_s2;

  // NOTE: during reset s2 and s3 are both loaded from s1, so a level already present
  // at release (e.g. load held high mid-frame) is never mistaken for an edge.
  always_ff @(posedge clk) begin
    sck_s1  <= sck;
    sdi_s1  <= sdi;
    load_s1 <= load;
    sck_s2  <= sck_s1;
    sdi_s2  <= sdi_s1;
    load_s2 <= load_s1;
    sck_s3  <= reset ? sck_s2 : sck_s1;
    load_s3 <= reset ? load_s2 : load_s1;
  end

  logic sck_rise, load_rise, load_fall;
  assign sck_rise  = sck_s2 & ~sck_s3;
  assign load_rise = load_s2 & ~load_s3;
  assign load_fall = ~load_s2 & load_s3;

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      tmo       <= '0;
      val       <= RESET_VAL;
      val_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      val_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load_rise) begin
            state <= ACTIVE;
            busy  <= 1'b1;
            cnt   <= '0;
            tmo   <= '0;
          end
        end
        ACTIVE: begin
          // A load fall wins over a coincident sck edge: that bit is dropped.
          if (load_fall) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt == 4'd8) begin
              val       <= shreg;
              val_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (tmo == TMO_LIMIT) begin
            state     <= ABORT;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (sck_rise && load_s2) begin
            shreg <= {shreg[6:0], sdi_s2};
            if (cnt != 4'd9) cnt <= cnt + 4'd1;
            tmo <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        ABORT: begin
          if (load_fall) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_CMD_RX_READBACK_EN
  logic       sck_fall;
  logic [7:0] txreg;
  assign sck_fall = ~sck_s2 & sck_s3;

  // Previous command is shifted out on sck falls so it is settled before each master sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txreg <= '0;
    end else if (state == IDLE && load_rise) begin
      txreg <= val;
    end else if (state == ACTIVE && sck_fall) begin
      txreg <= {txreg[6:0], 1'b0};
    end
  end
  assign sdo = txreg[7];
`else
  assign sdo = 1'b0;
`endif

endmodule
